// File: rtl/game_timer_driver.sv
// game_timer_driver: Avalon-MM master that programs and services the game interval timer
// Optional snapshot support is enabled by defining GAME_TIMER_DRIVER_SNAPSHOT_EN.
// Ports:
//   clk, reset                - system clock, synchronous active-high reset
//   cfg_start, cfg_period     - start pulse and tick period in clk cycles (IDLE only)
//   cfg_stop                  - stop pulse (RUN only)
//   snap_req                  - counter snapshot request pulse (RUN only)
//   busy, running             - sequence in progress / timer started
//   tick, tick_count          - pulse and wrapping count of serviced timeouts
//   snap_valid, snap_value    - snapshot update pulse and last captured counter
//   m_address .. m_writedata  - timer slave register bus (master side)
//   m_readdata, m_irq         - registered slave read data and level timeout interrupt
module game_timer_driver #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              m_irq
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, ACK, STOP_WR, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       load_q;
    logic              running_q;
    logic [TICK_W-1:0] tick_count_q;
    logic              snap_go;

`ifdef GAME_TIMER_DRIVER_SNAPSHOT_EN
    logic [31:0] snap_q;
    assign snap_go = snap_req;
    // The high half arrives on the bus in SNAP_CAP, so it is forwarded directly
    // to line up snap_value with the snap_valid pulse.
    assign snap_valid = state_q == SNAP_CAP;
    assign snap_value = state_q == SNAP_CAP ? {m_readdata, snap_q[15:0]} : snap_q;
`else
    logic unused_snap;
    assign unused_snap = ^{snap_req, m_readdata};
    assign snap_go = 1'b0;
    assign snap_valid = 1'b0;
    assign snap_value = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            load_q       <= 32'd0;
            running_q    <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cfg_start)
                load_q <= cfg_period == 32'd0 ? 32'd0 : cfg_period - 32'd1;
            if (state_q == WR_CTRL)
                running_q <= 1'b1;
            else if (state_q == STOP_WR)
                running_q <= 1'b0;
            if (state_q == ACK)
                tick_count_q <= tick_count_q + 1'b1;
        end
    end

`ifdef GAME_TIMER_DRIVER_SNAPSHOT_EN
    always_ff @(posedge clk) begin
        if (reset)
            snap_q <= 32'd0;
        else if (state_q == SNAP_RH)
            snap_q[15:0] <= m_readdata;
        else if (state_q == SNAP_CAP)
            snap_q[31:16] <= m_readdata;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = cfg_start ? WR_PL : IDLE;
            WR_PL:    state_d = WR_PH;
            WR_PH:    state_d = WR_CTRL;
            WR_CTRL:  state_d = RUN;
            RUN:      state_d = m_irq ? ACK : cfg_stop ? STOP_WR : snap_go ? SNAP_WR : RUN;
            ACK:      state_d = RUN;
            STOP_WR:  state_d = IDLE;
`ifdef GAME_TIMER_DRIVER_SNAPSHOT_EN
            SNAP_WR:  state_d = SNAP_RL;
            SNAP_RL:  state_d = SNAP_RH;
            SNAP_RH:  state_d = SNAP_CAP;
            SNAP_CAP: state_d = RUN;
`endif
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = 3'd0;
        m_writedata  = 16'd0;
        case (state_q)
            WR_PL:   begin m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd2; m_writedata = load_q[15:0];  end
            WR_PH:   begin m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd3; m_writedata = load_q[31:16]; end
            WR_CTRL: begin m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd1; m_writedata = 16'h0007;      end
            ACK:     begin m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd0;                              end
            STOP_WR: begin m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd1; m_writedata = 16'h0008;      end
`ifdef GAME_TIMER_DRIVER_SNAPSHOT_EN
            SNAP_WR: begin m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd4;                              end
            SNAP_RL: m_address = 3'd4;
            SNAP_RH: m_address = 3'd5;
`endif
            default: ;
        endcase
    end

    assign busy       = state_q != IDLE && state_q != RUN;
    assign running    = running_q;
    assign tick       = state_q == ACK;
    assign tick_count = tick_count_q;
endmodule

// File: tb/tb_game_timer_driver.sv
// tb_game_timer_driver: randomized self-checking bench with a behavioural timer slave
module tb_game_timer_driver;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0, cfg_stop = 1'b0, snap_req = 1'b0;
    logic [31:0]   cfg_period = 32'd0;
    logic          busy, running, tick, snap_valid;
    logic [TW-1:0] tick_count;
    logic [31:0]   snap_value;
    logic [2:0]    m_address;
    logic          m_chipselect, m_write_n, m_irq;
    logic [15:0]   m_writedata, m_readdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_timer_driver #(.TICK_W(TW)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_stop(cfg_stop), .snap_req(snap_req), .busy(busy), .running(running),
        .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_irq(m_irq)
    );

    // Interval timer slave: counts down from period, flags a timeout at zero and reloads.
    logic [31:0] t_period, t_counter, t_snap;
    logic        t_run, t_cont, t_ito, t_to;
    assign m_irq = t_to & t_ito;

    always @(posedge clk) begin
        if (reset) begin
            t_period <= 0; t_counter <= 0; t_snap <= 0;
            t_run <= 0; t_cont <= 0; t_ito <= 0; t_to <= 0; m_readdata <= 0;
        end else begin
            if (t_run) begin
                if (t_counter == 0) begin
                    t_to <= 1'b1;
                    t_counter <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                end else t_counter <= t_counter - 1;
            end
            if (m_chipselect && !m_write_n) begin
                case (m_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        if (m_writedata[3]) t_run <= 1'b0;
                        else if (m_writedata[2]) t_run <= 1'b1;
                        t_cont <= m_writedata[1];
                        t_ito  <= m_writedata[0];
                    end
                    3'd2: begin t_period[15:0] <= m_writedata; t_counter <= {t_period[31:16], m_writedata}; end
                    3'd3: begin t_period[31:16] <= m_writedata; t_counter <= {m_writedata, t_period[15:0]}; end
                    3'd4: t_snap <= t_counter;
                    default: ;
                endcase
            end
            m_readdata <= m_address == 3'd4 ? t_snap[15:0] : m_address == 3'd5 ? t_snap[31:16] : 16'd0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset;
        reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0; cfg_period = 32'd0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic start_timer(input logic [31:0] p);
        cfg_period = p; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(3);
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({busy, running, tick, snap_valid, m_chipselect, m_write_n, m_address, m_writedata, tick_count, snap_value}
            !== {5'b0, 1'b1, 3'd0, 16'd0, {TW{1'b0}}, 32'd0}) begin
            failures++;
            $display("FAIL reset_values busy=%b run=%b tick=%b sv=%b cs=%b wn=%b a=%0d wd=%h tc=%0d snap=%h",
                     busy, running, tick, snap_valid, m_chipselect, m_write_n, m_address, m_writedata, tick_count, snap_value);
        end
    endtask

    task automatic test_start;
        logic [31:0] p, ld;
        for (int i = 0; i < 6; i++) begin
            p = i == 0 ? 32'd100 : i == 1 ? 32'd0 : i == 2 ? 32'd1 : i == 3 ? 32'hFFFF_FFFF : $urandom;
            ld = p == 0 ? 32'd0 : p - 32'd1;
            do_reset();
            cfg_period = p; cfg_start = 1'b1;
            step(1);
            cfg_start = 1'b0;
            checks++;
            if ({m_chipselect, m_write_n, m_address, m_writedata, busy, running} !== {1'b1, 1'b0, 3'd2, ld[15:0], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL start_pl p=%h got cs=%b wn=%b a=%0d wd=%h busy=%b run=%b exp wd=%h",
                         p, m_chipselect, m_write_n, m_address, m_writedata, busy, running, ld[15:0]);
            end
            step(1);
            checks++;
            if ({m_chipselect, m_write_n, m_address, m_writedata, busy, running} !== {1'b1, 1'b0, 3'd3, ld[31:16], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL start_ph p=%h got cs=%b wn=%b a=%0d wd=%h busy=%b run=%b exp wd=%h",
                         p, m_chipselect, m_write_n, m_address, m_writedata, busy, running, ld[31:16]);
            end
            step(1);
            checks++;
            if ({m_chipselect, m_write_n, m_address, m_writedata, busy, running} !== {1'b1, 1'b0, 3'd1, 16'h0007, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL start_ctrl p=%h got cs=%b wn=%b a=%0d wd=%h busy=%b run=%b exp wd=0007",
                         p, m_chipselect, m_write_n, m_address, m_writedata, busy, running);
            end
            step(1);
            checks++;
            if ({m_chipselect, m_write_n, busy, running} !== {1'b0, 1'b1, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL start_run p=%h got cs=%b wn=%b busy=%b run=%b exp cs=0 wn=1 busy=0 run=1",
                         p, m_chipselect, m_write_n, busy, running);
            end
        end
    endtask

    // A window of K periods plus half a period holds exactly K completed acks.
    task automatic test_ticks;
        int p, k, w, nt;
        logic pi, rise;
        for (int r = 0; r < 3; r++) begin
            p = (r == 0) ? 100 : $urandom_range(8, 40);
            k = (r == 0) ? 10 : $urandom_range(2, 8);
            w = p * k + p / 2;
            do_reset();
            start_timer(p);
            nt = 0; pi = m_irq; rise = 1'b0;
            repeat (w) begin
                step(1);
                if (rise) begin
                    checks++;
                    if ({m_chipselect, m_write_n, m_address, m_writedata, tick} !== {1'b1, 1'b0, 3'd0, 16'd0, 1'b1}) begin
                        failures++;
                        $display("FAIL irq_ack got cs=%b wn=%b a=%0d wd=%h tick=%b exp ack write to addr0 with tick",
                                 m_chipselect, m_write_n, m_address, m_writedata, tick);
                    end
                end
                if (tick) nt++;
                rise = m_irq && !pi;
                pi = m_irq;
            end
            checks++;
            if (tick_count !== TW'(k) || nt != k) begin
                failures++;
                $display("FAIL tick_total p=%0d got count=%0d pulses=%0d exp %0d", p, tick_count, nt, k);
            end
        end
    endtask

    task automatic test_wrap;
        int nr, cyc;
        logic pi;
        do_reset();
        start_timer(8);
        nr = 0; cyc = 0; pi = m_irq;
        while (nr < 17 && cyc < 600) begin
            step(1);
            cyc++;
            if (m_irq && !pi) nr++;
            pi = m_irq;
        end
        step(2);
        checks++;
        if (nr != 17 || tick_count !== TW'(17 % (1 << TW))) begin
            failures++;
            $display("FAIL tick_wrap irqs=%0d got count=%0d exp %0d", nr, tick_count, 17 % (1 << TW));
        end
    endtask

    task automatic test_irq_stop;
        int cyc;
        do_reset();
        start_timer(20);
        cyc = 0;
        while (!m_irq && cyc < 200) begin step(1); cyc++; end
        checks++;
        if (!m_irq) begin
            failures++;
            $display("FAIL irq_wait got irq=0 exp irq=1 within 200 cycles");
        end
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
        checks++;
        if ({tick, m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'd0}) begin
            failures++;
            $display("FAIL irq_priority got tick=%b cs=%b wn=%b a=%0d wd=%h exp ack write", tick, m_chipselect, m_write_n, m_address, m_writedata);
        end
        step(1);
        checks++;
        if ({running, busy, m_chipselect} !== {1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_dropped got run=%b busy=%b cs=%b exp run=1 busy=0 cs=0", running, busy, m_chipselect);
        end
        step(1);
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
        checks++;
        if ({m_chipselect, m_write_n, m_address, m_writedata, busy} !== {1'b1, 1'b0, 3'd1, 16'h0008, 1'b1}) begin
            failures++;
            $display("FAIL stop_write got cs=%b wn=%b a=%0d wd=%h busy=%b exp addr1=0008", m_chipselect, m_write_n, m_address, m_writedata, busy);
        end
        step(1);
        checks++;
        if ({running, busy, m_chipselect} !== 3'b000) begin
            failures++;
            $display("FAIL stop_idle got run=%b busy=%b cs=%b exp 0 0 0", running, busy, m_chipselect);
        end
    endtask

    task automatic test_snapshot;
        logic [31:0] ex;
        do_reset();
        start_timer($urandom_range(300, 600));
`ifdef GAME_TIMER_DRIVER_SNAPSHOT_EN
        for (int r = 0; r < 3; r++) begin
            step($urandom_range(1, 20));
            snap_req = 1'b1;
            step(1);
            snap_req = 1'b0;
            checks++;
            if ({m_chipselect, m_write_n, m_address, busy} !== {1'b1, 1'b0, 3'd4, 1'b1}) begin
                failures++;
                $display("FAIL snap_write got cs=%b wn=%b a=%0d busy=%b exp write addr4", m_chipselect, m_write_n, m_address, busy);
            end
            step(1);
            checks++;
            if ({m_chipselect, m_write_n, m_address, snap_valid} !== {1'b0, 1'b1, 3'd4, 1'b0}) begin
                failures++;
                $display("FAIL snap_rl got cs=%b wn=%b a=%0d sv=%b exp read addr4", m_chipselect, m_write_n, m_address, snap_valid);
            end
            step(1);
            checks++;
            if ({m_chipselect, m_write_n, m_address, snap_valid} !== {1'b0, 1'b1, 3'd5, 1'b0}) begin
                failures++;
                $display("FAIL snap_rh got cs=%b wn=%b a=%0d sv=%b exp read addr5", m_chipselect, m_write_n, m_address, snap_valid);
            end
            step(1);
            ex = t_snap;
            checks++;
            if (snap_valid !== 1'b1 || snap_value !== ex) begin
                failures++;
                $display("FAIL snap_value got sv=%b val=%h exp sv=1 val=%h", snap_valid, snap_value, ex);
            end
            step(1);
            checks++;
            if (snap_valid !== 1'b0 || snap_value !== ex || busy !== 1'b0) begin
                failures++;
                $display("FAIL snap_hold got sv=%b val=%h busy=%b exp sv=0 val=%h busy=0", snap_valid, snap_value, busy, ex);
            end
        end
`else
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        checks++;
        if ({busy, m_chipselect, snap_valid} !== 3'b000) begin
            failures++;
            $display("FAIL snap_ignored got busy=%b cs=%b sv=%b exp 0 0 0", busy, m_chipselect, snap_valid);
        end
        step(3);
        checks++;
        if (snap_valid !== 1'b0 || snap_value !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL snap_tied got sv=%b val=%h busy=%b exp 0 0 0", snap_valid, snap_value, busy);
        end
        ex = 32'd0;
`endif
    endtask

    task automatic test_dropped;
        do_reset();
        start_timer(1000);
        cfg_period = 32'd5; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        checks++;
        if ({busy, m_chipselect, running} !== 3'b001) begin
            failures++;
            $display("FAIL start_in_run got busy=%b cs=%b run=%b exp 0 0 1", busy, m_chipselect, running);
        end
        do_reset();
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
        checks++;
        if ({busy, m_chipselect, running} !== 3'b000) begin
            failures++;
            $display("FAIL stop_in_idle got busy=%b cs=%b run=%b exp 0 0 0", busy, m_chipselect, running);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        do_reset();
        start_timer(8);
        cyc = 0;
        while (!tick && cyc < 100) begin step(1); cyc++; end
        step(1);
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
        step(1);
        cfg_period = $urandom; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(1);
        checks++;
        if ({busy, m_address, tick_count} !== {1'b1, 3'd3, TW'(1)}) begin
            failures++;
            $display("FAIL pre_reset got busy=%b a=%0d tc=%0d exp busy=1 a=3 tc=1", busy, m_address, tick_count);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({busy, running, tick, snap_valid, m_chipselect, m_write_n, m_address, m_writedata, tick_count, snap_value}
            !== {5'b0, 1'b1, 3'd0, 16'd0, {TW{1'b0}}, 32'd0}) begin
            failures++;
            $display("FAIL reset_mid busy=%b run=%b tick=%b sv=%b cs=%b wn=%b a=%0d wd=%h tc=%0d snap=%h exp reset values",
                     busy, running, tick, snap_valid, m_chipselect, m_write_n, m_address, m_writedata, tick_count, snap_value);
        end
        step(1);
        checks++;
        if ({busy, m_chipselect} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_idle got busy=%b cs=%b exp 0 0", busy, m_chipselect);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ticks();
        test_wrap();
        test_irq_stop();
        test_snapshot();
        test_dropped();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
